// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x3 matrix keypad scanner with press/release debounce
//
// Purpose: drives the keypad rows one at a time, samples the columns once per
// row dwell, debounces presses and releases, and presents a 4-bit key code
// (0-9 digits, 4'hA load, 4'hB clear, 4'hF no key).
//
// Ports:
//   sys_clk    in   system clock, all logic on the rising edge
//   sys_rst    in   asynchronous active-high reset
//   col_n[2:0] in   keypad columns, active-low, asynchronous to sys_clk
//   row_n[3:0] out  keypad row drive, active-low, exactly one bit low
//   key_code   out  debounced code of the held key, 4'hF when none
//   key_valid  out  one-cycle pulse per accepted press
//   key_held   out  high while an accepted key is held
module keypad_scanner #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 10
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [2:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {
    S_SCAN,
    S_DEBOUNCE,
    S_HELD
  } state_t;

  state_t           r_state;
  logic [2:0]       r_sync1;
  logic [2:0]       r_sync2;
  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_row;
  logic [3:0]       r_row_n;
  logic [3:0]       r_cand;
  logic [3:0]       r_key_code;
  logic             r_key_valid;
  logic             r_key_held;

  logic       w_tick;
  logic       w_hit;
  logic [1:0] w_col;
  logic [3:0] w_code;
  logic [1:0] w_row_next;
  logic [3:0] w_row_n_next;

  assign row_n     = r_row_n;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;

  // Two-flop synchronizer; reset to "all released" so no phantom hit.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_sync1 <= 3'b111;
      r_sync2 <= 3'b111;
    end else begin
      r_sync1 <= col_n;
      r_sync2 <= r_sync1;
    end
  end

  // Free-running dwell counter; the row only changes right after a tick,
  // which leaves SCAN_DIV-1 cycles for the synchronizer to settle.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  assign w_tick = (r_div == DIV_LAST);
  assign w_hit  = ~&r_sync2;
  // Lowest active column wins when several are low.
  assign w_col  = !r_sync2[0] ? 2'd0 : (!r_sync2[1] ? 2'd1 : 2'd2);

  assign w_row_next   = r_row + 2'd1;
  assign w_row_n_next = ~(4'b0001 << w_row_next);

  // Rows 0-2 carry digits 1-9 in order; row 3 is A, 0, B.
  always_comb begin
    w_code = 4'hF;
    if (r_row == 2'd3) begin
      case (w_col)
        2'd0:    w_code = 4'hA;
        2'd1:    w_code = 4'h0;
        default: w_code = 4'hB;
      endcase
    end else begin
      w_code = ({2'b00, r_row} * 4'd3) + {2'b00, w_col} + 4'd1;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state     <= S_SCAN;
      r_cnt       <= '0;
      r_row       <= 2'd0;
      r_row_n     <= 4'b1110;
      r_cand      <= 4'hF;
      r_key_code  <= 4'hF;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      if (w_tick) begin
        case (r_state)
          S_SCAN: begin
            if (w_hit) begin
              // Freeze the row on the first sighting of a key.
              r_cand  <= w_code;
              r_cnt   <= CNT_W'(1);
              r_state <= S_DEBOUNCE;
            end else begin
              r_row   <= w_row_next;
              r_row_n <= w_row_n_next;
            end
          end
          S_DEBOUNCE: begin
            if (w_hit && (w_code == r_cand)) begin
              if (r_cnt == CNT_LAST) begin
                r_key_code  <= r_cand;
                r_key_valid <= 1'b1;
                r_key_held  <= 1'b1;
                r_cnt       <= '0;
                r_state     <= S_HELD;
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end else begin
              r_cnt   <= '0;
              r_row   <= w_row_next;
              r_row_n <= w_row_n_next;
              r_state <= S_SCAN;
            end
          end
          S_HELD: begin
            // Any contact restarts the release count, even a different key.
            if (w_hit) begin
              r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
              r_key_code <= 4'hF;
              r_key_held <= 1'b0;
              r_cnt      <= '0;
              r_row      <= w_row_next;
              r_row_n    <= w_row_n_next;
              r_state    <= S_SCAN;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          default: begin
            r_cnt   <= '0;
            r_state <= S_SCAN;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench for keypad_scanner
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DB = 3;
  localparam int M_SCAN = 0;
  localparam int M_DEB  = 1;
  localparam int M_HELD = 2;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [2:0] col_n;
  logic [3:0] row_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  // Pressed keys, bit index = row*3 + col.
  logic [11:0] mask = '0;

  int checks   = 0;
  int failures = 0;

  logic [3:0] keymap [12] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
                              4'h7, 4'h8, 4'h9, 4'hA, 4'h0, 4'hB};
  logic [3:0] rot [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  // Reference model state
  int          m_k;
  int          m_ticks;
  int          m_row;
  int          m_mode;
  int          m_streak;
  logic [3:0]  m_cand;
  logic [3:0]  m_code;
  logic        m_valid;
  logic        m_held;
  logic [11:0] hist [3];

  int         dut_pulses = 0;
  int         mod_pulses = 0;
  logic [3:0] dut_last   = 4'hF;
  int         trace_err  = 0;

  always #5 sys_clk = ~sys_clk;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .col_n    (col_n),
    .row_n    (row_n),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  // A pressed key shorts its column to its row only while that row is driven.
  always_comb begin
    col_n = 3'b111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (mask[r*3+c] && !row_n[r]) col_n[c] = 1'b0;
  end

  task automatic reset_model();
    m_k = 0; m_ticks = 0; m_row = 0; m_mode = M_SCAN; m_streak = 0;
    m_cand = 4'hF; m_code = 4'hF; m_valid = 1'b0; m_held = 1'b0;
    hist[0] = '0; hist[1] = '0; hist[2] = '0;
  endtask

  task automatic model_tick();
    bit         hit;
    logic [3:0] code;
    hit = 1'b0;
    code = 4'hF;
    for (int c = 0; c < 3; c++)
      if (!hit && hist[2][m_row*3+c]) begin
        hit = 1'b1;
        code = keymap[m_row*3+c];
      end
    m_ticks++;
    if (m_mode == M_SCAN) begin
      if (hit) begin
        m_cand = code; m_streak = 1; m_mode = M_DEB;
      end else m_row = (m_row + 1) % 4;
    end else if (m_mode == M_DEB) begin
      if (hit && code == m_cand) begin
        m_streak++;
        if (m_streak == DB) begin
          m_code = m_cand; m_valid = 1'b1; m_held = 1'b1;
          m_streak = 0; m_mode = M_HELD;
        end
      end else begin
        m_streak = 0; m_row = (m_row + 1) % 4; m_mode = M_SCAN;
      end
    end else begin
      if (hit) m_streak = 0;
      else begin
        m_streak++;
        if (m_streak == DB) begin
          m_code = 4'hF; m_held = 1'b0; m_streak = 0;
          m_row = (m_row + 1) % 4; m_mode = M_SCAN;
        end
      end
    end
  endtask

  // One clock of DUT and model; columns reach the decision two edges late.
  task automatic step();
    logic [3:0] exp_row;
    @(posedge sys_clk);
    #1;
    m_k++;
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = mask;
    m_valid = 1'b0;
    if (m_k % SD == 0) model_tick();
    if (key_valid === 1'b1) begin
      dut_pulses++;
      dut_last = key_code;
    end
    if (m_valid) mod_pulses++;
    exp_row = 4'b0001 << m_row;
    if (row_n !== ~exp_row || key_code !== m_code ||
        key_valid !== m_valid || key_held !== m_held)
      trace_err++;
  endtask

  task automatic run_ticks(input int n);
    int t0;
    int guard;
    t0 = m_ticks;
    guard = 0;
    while ((m_ticks - t0) < n && guard < (n + 1) * SD) begin
      step();
      guard++;
    end
    if ((m_ticks - t0) < n) begin
      checks++; failures++;
      $display("FAIL run_ticks timeout: ticks=%0d required=%0d", m_ticks - t0, n);
    end
  endtask

  task automatic release_all();
    mask = '0;
    run_ticks(6);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    reset_model();
    repeat (6) step();
    sys_rst = 1'b1;
    #1;
    checks++; if (row_n !== 4'b1110) begin failures++; $display("FAIL reset_row_n: got=%b exp=1110", row_n); end
    checks++; if (key_code !== 4'hF) begin failures++; $display("FAIL reset_key_code: got=%h exp=f", key_code); end
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL reset_key_valid: got=%b exp=0", key_valid); end
    checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL reset_key_held: got=%b exp=0", key_held); end
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    reset_model();
    for (int k = 1; k <= 16; k++) begin
      step();
      checks++;
      if (row_n !== rot[(k / 4) % 4]) begin
        failures++;
        $display("FAIL reset_rotation cycle %0d: got=%b exp=%b", k, row_n, rot[(k / 4) % 4]);
      end
    end
  endtask

  task automatic test_clean_press();
    int p0;
    int e0;
    p0 = dut_pulses; e0 = trace_err;
    mask[4] = 1'b1;
    run_ticks(10);
    checks++; if (dut_pulses - p0 != 1) begin failures++; $display("FAIL clean_pulses: got=%0d exp=1", dut_pulses - p0); end
    checks++; if (dut_last !== 4'h5) begin failures++; $display("FAIL clean_code: got=%h exp=5", dut_last); end
    checks++; if (key_held !== 1'b1) begin failures++; $display("FAIL clean_held: got=%b exp=1", key_held); end
    mask = '0;
    run_ticks(2);
    checks++; if (key_code !== 4'h5 || key_held !== 1'b1) begin failures++; $display("FAIL clean_release_early: code=%h held=%b exp=5/1", key_code, key_held); end
    run_ticks(1);
    checks++; if (key_code !== 4'hF || key_held !== 1'b0) begin failures++; $display("FAIL clean_release: code=%h held=%b exp=f/0", key_code, key_held); end
    release_all();
    checks++; if (trace_err != e0) begin failures++; $display("FAIL clean_trace: mismatched_cycles=%0d exp=0", trace_err - e0); end
  endtask

  task automatic test_bouncy_press();
    int p0;
    int e0;
    p0 = dut_pulses; e0 = trace_err;
    for (int i = 0; i < 6; i++) begin
      mask[2] = (i % 2 == 0);
      run_ticks(1);
    end
    checks++; if (dut_pulses != p0) begin failures++; $display("FAIL bounce_no_pulse: got=%0d exp=0", dut_pulses - p0); end
    mask[2] = 1'b1;
    run_ticks(10);
    checks++; if (dut_pulses - p0 != 1 || dut_last !== 4'h3) begin failures++; $display("FAIL bounce_accept: pulses=%0d code=%h exp=1/3", dut_pulses - p0, dut_last); end
    release_all();
    checks++; if (trace_err != e0) begin failures++; $display("FAIL bounce_trace: mismatched_cycles=%0d exp=0", trace_err - e0); end
  endtask

  task automatic test_bouncy_release();
    int p0;
    int e0;
    p0 = dut_pulses; e0 = trace_err;
    mask[9] = 1'b1;
    run_ticks(10);
    checks++; if (dut_pulses - p0 != 1 || dut_last !== 4'hA) begin failures++; $display("FAIL relbounce_accept: pulses=%0d code=%h exp=1/a", dut_pulses - p0, dut_last); end
    mask[9] = 1'b0; run_ticks(2);
    mask[9] = 1'b1; run_ticks(1);
    mask[9] = 1'b0; run_ticks(2);
    checks++; if (key_code !== 4'hA || key_held !== 1'b1) begin failures++; $display("FAIL relbounce_glitch: code=%h held=%b exp=a/1", key_code, key_held); end
    run_ticks(1);
    checks++; if (key_code !== 4'hF || key_held !== 1'b0) begin failures++; $display("FAIL relbounce_release: code=%h held=%b exp=f/0", key_code, key_held); end
    checks++; if (dut_pulses - p0 != 1) begin failures++; $display("FAIL relbounce_single: got=%0d exp=1", dut_pulses - p0); end
    release_all();
    checks++; if (trace_err != e0) begin failures++; $display("FAIL relbounce_trace: mismatched_cycles=%0d exp=0", trace_err - e0); end
  endtask

  task automatic test_multi_column();
    int p0;
    p0 = dut_pulses;
    mask[3] = 1'b1;
    mask[5] = 1'b1;
    run_ticks(10);
    checks++; if (dut_pulses - p0 != 1 || dut_last !== 4'h4) begin failures++; $display("FAIL multi_col: pulses=%0d code=%h exp=1/4", dut_pulses - p0, dut_last); end
    release_all();
  endtask

  task automatic test_held_second_key();
    int p0;
    int e0;
    p0 = dut_pulses; e0 = trace_err;
    mask[11] = 1'b1;
    run_ticks(10);
    checks++; if (dut_pulses - p0 != 1 || dut_last !== 4'hB) begin failures++; $display("FAIL second_first: pulses=%0d code=%h exp=1/b", dut_pulses - p0, dut_last); end
    mask[0] = 1'b1;
    run_ticks(6);
    checks++; if (key_code !== 4'hB || dut_pulses - p0 != 1) begin failures++; $display("FAIL second_hidden: code=%h pulses=%0d exp=b/1", key_code, dut_pulses - p0); end
    mask[11] = 1'b0;
    run_ticks(2);
    checks++; if (key_code !== 4'hB) begin failures++; $display("FAIL second_release_early: got=%h exp=b", key_code); end
    run_ticks(1);
    checks++; if (key_code !== 4'hF) begin failures++; $display("FAIL second_release: got=%h exp=f", key_code); end
    run_ticks(3);
    checks++; if (dut_pulses - p0 != 2 || dut_last !== 4'h1) begin failures++; $display("FAIL second_key: pulses=%0d code=%h exp=2/1", dut_pulses - p0, dut_last); end
    release_all();
    checks++; if (trace_err != e0) begin failures++; $display("FAIL second_trace: mismatched_cycles=%0d exp=0", trace_err - e0); end
  endtask

  task automatic test_reset_during_debounce();
    int p0;
    int g;
    p0 = dut_pulses;
    mask[8] = 1'b1;
    g = 0;
    while (m_mode != M_DEB && g < 40) begin
      step();
      g++;
    end
    checks++; if (m_mode != M_DEB) begin failures++; $display("FAIL rstdeb_reach: model never entered debounce within %0d cycles", g); end
    sys_rst = 1'b1;
    #1;
    checks++; if (key_valid !== 1'b0 || key_code !== 4'hF || key_held !== 1'b0 || row_n !== 4'b1110)
      begin failures++; $display("FAIL rstdeb_abort: valid=%b code=%h held=%b row_n=%b exp=0/f/0/1110", key_valid, key_code, key_held, row_n); end
    checks++; if (dut_pulses != p0) begin failures++; $display("FAIL rstdeb_no_pulse: got=%0d exp=0", dut_pulses - p0); end
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    reset_model();
    run_ticks(8);
    checks++; if (dut_pulses - p0 != 1 || dut_last !== 4'h9) begin failures++; $display("FAIL rstdeb_accept: pulses=%0d code=%h exp=1/9", dut_pulses - p0, dut_last); end
    release_all();
  endtask

  task automatic test_random();
    int p0;
    int e0;
    int k;
    int h;
    e0 = trace_err;
    for (int it = 0; it < 8; it++) begin
      k = $urandom_range(0, 11);
      h = $urandom_range(8, 14);
      repeat ($urandom_range(0, 3)) step();
      p0 = dut_pulses;
      mask = 12'(1) << k;
      run_ticks(h);
      checks++; if (dut_pulses - p0 != 1 || dut_last !== keymap[k]) begin failures++; $display("FAIL random_key%0d: pulses=%0d code=%h exp=1/%h", k, dut_pulses - p0, dut_last, keymap[k]); end
      mask = '0;
      run_ticks(6);
      checks++; if (key_code !== 4'hF || key_held !== 1'b0) begin failures++; $display("FAIL random_release%0d: code=%h held=%b exp=f/0", k, key_code, key_held); end
    end
    checks++; if (trace_err != e0) begin failures++; $display("FAIL random_trace: mismatched_cycles=%0d exp=0", trace_err - e0); end
    checks++; if (dut_pulses != mod_pulses) begin failures++; $display("FAIL total_pulses: got=%0d exp=%0d", dut_pulses, mod_pulses); end
  endtask

  initial begin
    reset_model();
    test_reset();
    test_clean_press();
    test_bouncy_press();
    test_bouncy_release();
    test_multi_column();
    test_held_second_key();
    test_reset_during_debounce();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Front-end scanner for the 4x3 matrix keypad. It drives the four rows one at a time and samples the three columns. It debounces each press and release, then presents the same 4-bit key code that the load/clear FSM consumes on its key input (digits 0-9, 4'hA = load, 4'hB = clear, 4'hF = no key). It sits between the board keypad pins and the FSM, and replaces direct code injection on that input.

## Interface
- SCAN_DIV, 50000: sys_clk cycles each row is driven (dwell); must be >= 4.
- DEBOUNCE_CNT, 10: consecutive identical row samples required to accept a press or a release; must be >= 2.
- sys_clk  input  1  single system clock, all logic rising-edge.
- sys_rst  input  1  reset, asynchronous and active-high.
- col_n  input  3  keypad columns, active-low, pulled up, asynchronous to sys_clk.
- row_n  output  4  keypad row drive, active-low, exactly one bit low at all times.
- key_code  output  4  debounced code of the held key; 4'hF when no key.
- key_valid  output  1  one-cycle pulse when a new press is accepted.
- key_held  output  1  level, high while an accepted key is held.

## Operation
- col_n passes through a 2-flop synchronizer before use; the result is col_s.
- Dwell counter div counts 0..SCAN_DIV-1. tick = (div == SCAN_DIV-1). Only tick cycles sample col_s.
- Row r drives row_n = ~(4'b0001 << r).
- Key map, indexed by (row, lowest active column):
  - Row 0: 1, 2, 3.
  - Row 1: 4, 5, 6.
  - Row 2: 7, 8, 9.
  - Row 3: A, 0, B.
- If several columns are low, the lowest column index wins.
- The sample at a tick is hit = any column low, with code = map(r, column).
- States:
  - SCAN: on tick with no hit, r advances (3 wraps to 0). On tick with hit, cand <= code, cnt <= 1, go to DEBOUNCE; the row is frozen.
  - DEBOUNCE: on tick with hit and code == cand, cnt++. When cnt reaches DEBOUNCE_CNT, key_code <= cand, key_valid pulses, key_held <= 1, cnt <= 0, go to HELD. On tick with no hit or a different code, cnt <= 0, r advances, go to SCAN. No output changes.
  - HELD: the row stays frozen. On tick with hit, cnt <= 0, whether the code matches or not. On tick with no hit, cnt++. When cnt reaches DEBOUNCE_CNT, key_code <= 4'hF, key_held <= 0, cnt <= 0, r advances, go to SCAN.
- A second key pressed while one is held, on another row, is invisible because the row is frozen. It is detected only after the first key is released and scanning resumes.
- The counters are wide enough for SCAN_DIV-1 and DEBOUNCE_CNT; they never wrap in normal operation.

## Timing
- Reset values:
  - row_n = 4'b1110 (row 0).
  - key_code = 4'hF.
  - key_valid = 0, key_held = 0.
  - state SCAN, div = 0, cnt = 0, synchronizer = 3'b111.
- Reset asserted mid-debounce or mid-hold aborts immediately, with no key_valid. When released, scanning restarts at row 0.
- All outputs are registered.
- row_n changes on the cycle after a tick. The following SCAN_DIV-1 cycles cover the 2-cycle synchronizer settle.
- Press latency: key_valid, key_code and key_held update together on the clock edge of the DEBOUNCE_CNT-th consecutive matching tick. The first matching tick counts as tick 1.
- key_valid is high for exactly 1 cycle per accepted press. It never repeats while the key is held.
- Release latency: key_code returns to 4'hF on the DEBOUNCE_CNT-th consecutive no-hit tick in HELD.
- Minimum press recognised: DEBOUNCE_CNT*SCAN_DIV cycles of stable contact, plus up to 4*SCAN_DIV cycles of scan alignment.

## Test plan
Parameters for all scenarios: SCAN_DIV=4, DEBOUNCE_CNT=3. The column model pulls col_n low only while the matching row_n bit is low.

- Reset: assert sys_rst mid-dwell -> row_n=4'b1110, key_code=4'hF, key_valid=0, key_held=0. After release, row_n rotates 1110 -> 1101 -> 1011 -> 0111 -> 1110 every 4 cycles.
- Clean press of key 5 (row 1, col 1), held 40 cycles -> exactly one key_valid pulse and key_code=4'h5 on the 3rd matching tick. key_held=1 until 3 no-hit ticks after release, then key_code=4'hF.
- Bouncy press of key 3 (row 0, col 2): contact toggles on alternate ticks for 6 ticks, then stable -> no key_valid during the bounce; exactly one pulse with key_code=4'h3 after 3 stable ticks.
- Bouncy release of key A (row 3, col 0): after acceptance, the contact opens for 2 ticks, closes for 1, then opens -> key_code stays 4'hA through the glitch and returns to 4'hF only after 3 consecutive open ticks. There is no second key_valid.
- Keys 4 and 6 (row 1, col 0 and col 2) pressed together -> key_code=4'h4 (lowest column).
- Key B held while key 1 (row 0) is pressed, then B released while 1 is still held -> one pulse for 4'hB, 4'hF after the release debounce, then one pulse for 4'h1 after scanning reaches row 0.
- Reset asserted during DEBOUNCE with key 9 -> no key_valid. After reset is released, a full 3-tick debounce yields key_code=4'h9.
